aes_dec_key_sequencer: RTL and testbench
========================================

# aes_dec_key_sequencer

Sequential round-key server between `Inverse_key_expand` and the iterative AES-128 decryption datapath. It captures the 1408-bit round-key schedule in one cycle. It then streams the eleven 128-bit round keys in decryption order (round 10 down to round 0) over a valid/ready handshake. When `EQ_INV` is set, it applies InvMixColumns to round keys 1..9 so that an equivalent-inverse-cipher datapath can consume them directly.

## Interface
- `EQ_INV`, default 0: 1 applies InvMixColumns to rounds 1..9; rounds 0 and 10 are always passed raw.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `load`  in  1  capture `sched_in` and start streaming; honoured only when `busy`=0.
- `sched_in`  in  1408  schedule from key expansion; round k occupies bits [1407-128k -: 128], so round 0 (the cipher key) is [1407:1280] and round 10 is [127:0].
- `busy`  out  1  high from the cycle after an accepted `load` until the round-0 transfer completes.
- `rk_valid`  out  1  `rk_out` holds a round key.
- `rk_ready`  in  1  consumer accepts; a transfer occurs when `rk_valid` and `rk_ready` are both high.
- `rk_out`  out  128  round key; word [127:96] is column 0, and byte [31:24] of each word is row 0.
- `rk_round`  out  4  round index of `rk_out`, from 10 down to 0.
- `rk_last`  out  1  high with `rk_valid` when `rk_round`=0.
- `done`  out  1  one-cycle pulse in the cycle after the round-0 transfer.

## Operation
- The FSM has two states, IDLE and STREAM. The reset state is IDLE.
- IDLE:
  - `load`=1 latches `sched_in` into the 1408-bit schedule register and sets `idx`=10.
  - The FSM then moves to STREAM.
- STREAM:
  - `rk_out` = f(schedule[idx]), where f is the identity if `EQ_INV`=0 or `idx`∈{0,10}; otherwise f is InvMixColumns applied to each 32-bit column.
  - On a transfer with `idx`>0, `idx` decrements.
  - On a transfer with `idx`=0, the FSM returns to IDLE and asserts `done` in the next cycle.
- InvMixColumns per column (a0..a3 are the bytes from the top of the word), in GF(2^8) with polynomial 0x11b:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - Rows 1..3 use the same coefficients rotated.
- `load` is ignored in STREAM; `sched_in` may change freely while the block is busy.
- When `rk_valid`=1 and `rk_ready`=0, `rk_out`, `rk_round` and `rk_last` hold stable.
- `rk_ready` has no effect while `rk_valid`=0.
- Reset values: `busy`=0, `rk_valid`=0, `rk_out`=0, `rk_round`=0, `rk_last`=0, `done`=0, schedule register=0, state=IDLE.
- Reset asserted mid-stream:
  - The next edge returns the block to IDLE with all outputs at their reset values.
  - The stream is abandoned and no `done` is asserted.
- `load` in the same cycle as a `done` pulse (already IDLE) is accepted normally.

## Timing
- Accepted `load` at edge n leads to `rk_valid`=1, `rk_round`=10 and `busy`=1 after edge n.
- All outputs are registered or decoded from registered state and `idx`.
- The InvMixColumns path is combinational from the schedule register and `idx`, within a single cycle.
- With `rk_ready` held at 1, 11 transfers occur in 11 consecutive cycles, followed by `done` on the 12th cycle after the load edge.
- Throughput is one key per cycle, with no bubble between keys.
- Back-to-back streams have a minimum gap of one cycle: the `done` cycle can accept a new `load`.

## Structure
- Shared package `aes_pkg` holds:
  - Constants `NR`=10, `RK_W`=128, `SCHED_W`=1408.
  - The state enum {IDLE, STREAM}.
  - The `xtime` and `gf_mul` functions.
- Sub-module `aes_inv_mix_column`: 32-bit combinational InvMixColumns. It is instantiated 4× and bypassed through a mux when not in use.
- Top level contains the FSM, the `idx` counter, the schedule register and the output mux.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, schedule from the key expansion, `EQ_INV`=0, `rk_ready`=1:
  - First key is `rk_round`=10, d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Second is round 9, ac7766f319fadc2128d12941575c006e.
  - Last is 2b7e1516… with `rk_last`=1.
  - `done` pulses one cycle later.
- `EQ_INV`=1 with a crafted schedule whose round 5 has every column = 8e4da1bc:
  - Round 5 output is db135345 ×4.
  - Round 10 and round 0 outputs are unmodified.
- Backpressure: `rk_ready` toggled 1,0,0,1 on a random pattern:
  - `rk_out` and `rk_round` are stable while stalled.
  - All 11 keys are delivered in order, with none duplicated or dropped.
- `load` pulsed at `rk_round`=6 with a different `sched_in`:
  - It is ignored.
  - The remaining keys 5..0 come from the original schedule.
- `rst` asserted at `rk_round`=4:
  - On the next cycle all outputs are 0 and `busy`=0, with no `done`.
  - A following `load` restarts the stream at round 10.
- `load` held high continuously with `rk_ready`=1:
  - A new stream starts in the `done` cycle.
  - The stream period is 12 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the AES
// decryption key sequencer.
package aes_pkg;

    localparam int NR      = 10;
    localparam int RK_W    = 128;
    localparam int SCHED_W = 1408;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; InvMixColumns coefficients never exceed 4 bits.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] acc;
        logic [7:0] pow;
        acc = 8'h00;
        pow = a;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) begin
                acc = acc ^ pow;
            end
            pow = xtime(pow);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// Combinational InvMixColumns for one 32-bit column; byte [31:24] is row 0.
module aes_inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_a0;
    logic [7:0] w_a1;
    logic [7:0] w_a2;
    logic [7:0] w_a3;

    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    assign o_col[31:24] = gf_mul(w_a0, 4'he) ^ gf_mul(w_a1, 4'hb) ^ gf_mul(w_a2, 4'hd) ^ gf_mul(w_a3, 4'h9);
    assign o_col[23:16] = gf_mul(w_a0, 4'h9) ^ gf_mul(w_a1, 4'he) ^ gf_mul(w_a2, 4'hb) ^ gf_mul(w_a3, 4'hd);
    assign o_col[15:8]  = gf_mul(w_a0, 4'hd) ^ gf_mul(w_a1, 4'h9) ^ gf_mul(w_a2, 4'he) ^ gf_mul(w_a3, 4'hb);
    assign o_col[7:0]   = gf_mul(w_a0, 4'hb) ^ gf_mul(w_a1, 4'hd) ^ gf_mul(w_a2, 4'h9) ^ gf_mul(w_a3, 4'he);

endmodule

// File: rtl/aes_dec_key_sequencer.sv
// Captures an AES-128 round-key schedule and streams the keys round 10 down
// to round 0 over valid/ready, optionally pre-mixed for the equivalent inverse cipher.
module aes_dec_key_sequencer
    import aes_pkg::*;
#(
    parameter bit EQ_INV = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [SCHED_W-1:0] i_sched_in,
    output logic               o_busy,
    output logic               o_rk_valid,
    input  logic               i_rk_ready,
    output logic [RK_W-1:0]    o_rk_out,
    output logic [3:0]         o_rk_round,
    output logic               o_rk_last,
    output logic               o_done
);

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_idx;
    logic [3:0]         w_idx_next;
    logic [SCHED_W-1:0] r_sched;
    logic               r_done;
    logic               w_done_next;
    logic               w_load_accept;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= 4'd0;
            r_sched <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_done  <= w_done_next;
            if (w_load_accept) begin
                r_sched <= i_sched_in;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_done_next   = 1'b0;
        w_load_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_load) begin
                    w_load_accept = 1'b1;
                    w_idx_next    = 4'(NR);
                    w_state_next  = STREAM;
                end
            end
            STREAM: begin
                if (i_rk_ready) begin
                    if (r_idx == 4'd0) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_idx_next = r_idx - 4'd1;
                    end
                end
            end
        endcase
    end

    logic [RK_W-1:0] w_rk [0:NR];
    logic [RK_W-1:0] w_raw;
    logic [RK_W-1:0] w_mixed;
    logic [RK_W-1:0] w_key;
    logic            w_use_mix;
    logic            w_stream;

    // Round k sits at the top of the schedule for k=0, so unpack in that order.
    genvar g;
    for (g = 0; g <= NR; g++) begin : g_split
        assign w_rk[g] = r_sched[SCHED_W-1-RK_W*g -: RK_W];
    end

    assign w_raw = w_rk[r_idx];

    for (g = 0; g < 4; g++) begin : g_imc
        aes_inv_mix_column u_imc (
            .i_col (w_raw[RK_W-1-32*g -: 32]),
            .o_col (w_mixed[RK_W-1-32*g -: 32])
        );
    end

    assign w_use_mix = EQ_INV && (r_idx != 4'd0) && (r_idx != 4'(NR));
    assign w_key     = w_use_mix ? w_mixed : w_raw;

    assign w_stream   = (r_state == STREAM);
    assign o_busy     = w_stream;
    assign o_rk_valid = w_stream;
    assign o_rk_out   = w_stream ? w_key : '0;
    assign o_rk_round = w_stream ? r_idx : 4'd0;
    assign o_rk_last  = w_stream && (r_idx == 4'd0);
    assign o_done     = r_done;

endmodule

// File: tb/tb_aes_dec_key_sequencer.sv
// Self-checking bench: two sequencers (raw and equivalent-inverse) share stimulus
// and are compared against a behavioural round-key model.
module tb_aes_dec_key_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          load;
    logic          ready;
    logic [1407:0] sched;

    logic          busy0, valid0, last0, done0;
    logic [127:0]  out0;
    logic [3:0]    round0;
    logic          busy1, valid1, last1, done1;
    logic [127:0]  out1;
    logic [3:0]    round1;

    int vectors = 0;
    int miscompares = 0;

    logic [127:0]  fips_rk [0:10];
    logic [1407:0] fips_sched;

    aes_dec_key_sequencer #(.EQ_INV(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_sched_in(sched),
        .o_busy(busy0), .o_rk_valid(valid0), .i_rk_ready(ready),
        .o_rk_out(out0), .o_rk_round(round0), .o_rk_last(last0), .o_done(done0)
    );

    aes_dec_key_sequencer #(.EQ_INV(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_sched_in(sched),
        .o_busy(busy1), .o_rk_valid(valid1), .i_rk_ready(ready),
        .o_rk_out(out1), .o_rk_round(round1), .o_rk_last(last1), .o_done(done1)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input int c);
        logic [7:0] x;
        logic [7:0] r;
        int m;
        x = a;
        r = 8'h00;
        m = c;
        while (m != 0) begin
            if ((m & 1) != 0) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            m = m >> 1;
        end
        return r;
    endfunction

    // Expected key for round k: raw slice, InvMixColumns on rounds 1..9 when eq is set.
    function automatic logic [127:0] ref_key(input logic [1407:0] s, input int k, input bit eq);
        logic [127:0] raw;
        logic [127:0] res;
        logic [7:0]   a [0:3];
        raw = s[1407-128*k -: 128];
        if (!eq || k == 0 || k == 10) return raw;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = raw[127-32*c-8*i -: 8];
            for (int i = 0; i < 4; i++) begin
                res[127-32*c-8*i -: 8] = gmul(a[i], 14) ^ gmul(a[(i+1)%4], 11) ^
                                         gmul(a[(i+2)%4], 13) ^ gmul(a[(i+3)%4], 9);
            end
        end
        return res;
    endfunction

    function automatic logic [1407:0] rand_sched();
        logic [1407:0] s;
        for (int w = 0; w < 44; w++) s[32*w +: 32] = $urandom();
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; ready = 1'b0; sched = '0;
        tick(); tick();
        vectors++;
        if ({busy0, valid0, last0, done0, busy1, valid1, last1, done1} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_flags actual=%b required=%b",
                     {busy0, valid0, last0, done0, busy1, valid1, last1, done1}, 8'h00);
        end
        vectors++;
        if ({round0, round1} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_round actual=%h required=00", {round0, round1});
        end
        vectors++;
        if ({out0, out1} !== 256'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_key actual=%h/%h required=0", out0, out1);
        end
        rst = 1'b0;
        ready = 1'b1;
        tick();
        vectors++;
        if ({valid0, valid1, done0, done1} !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL idle_ready_no_effect actual=%b required=0000", {valid0, valid1, done0, done1});
        end
        ready = 1'b0;
    endtask

    task automatic test_fips();
        sched = fips_sched; load = 1'b1; ready = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 10; k >= 0; k--) begin
            vectors++;
            if ({valid0, busy0, valid1, busy1, done0, done1} !== 6'b111100) begin
                miscompares++;
                $display("[TB] FAIL fips_flags r%0d actual=%b required=111100", k,
                         {valid0, busy0, valid1, busy1, done0, done1});
            end
            vectors++;
            if ({round0, round1, last0, last1} !== {4'(k), 4'(k), k == 0, k == 0}) begin
                miscompares++;
                $display("[TB] FAIL fips_round actual=%h/%h last=%b%b required=%0d", round0, round1, last0, last1, k);
            end
            vectors++;
            if (out0 !== fips_rk[k]) begin
                miscompares++;
                $display("[TB] FAIL fips_key_raw r%0d actual=%h required=%h", k, out0, fips_rk[k]);
            end
            vectors++;
            if (out1 !== ref_key(fips_sched, k, 1'b1)) begin
                miscompares++;
                $display("[TB] FAIL fips_key_eqinv r%0d actual=%h required=%h", k, out1, ref_key(fips_sched, k, 1'b1));
            end
            tick();
        end
        vectors++;
        if ({done0, done1, valid0, valid1, busy0, busy1} !== 6'b110000) begin
            miscompares++;
            $display("[TB] FAIL fips_done actual=%b required=110000", {done0, done1, valid0, valid1, busy0, busy1});
        end
        ready = 1'b0;
        tick();
        vectors++;
        if ({done0, done1} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL done_one_cycle actual=%b required=00", {done0, done1});
        end
    endtask

    task automatic test_eqinv();
        logic [1407:0] s;
        s = rand_sched();
        s[1407-128*5 -: 128] = {4{32'h8e4da1bc}};
        sched = s; load = 1'b1; ready = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 10; k >= 0; k--) begin
            vectors++;
            if (out0 !== ref_key(s, k, 1'b0) || round0 !== 4'(k)) begin
                miscompares++;
                $display("[TB] FAIL eqinv_raw r%0d actual=%h round=%0d required=%h", k, out0, round0, ref_key(s, k, 1'b0));
            end
            vectors++;
            if (out1 !== ref_key(s, k, 1'b1) || round1 !== 4'(k)) begin
                miscompares++;
                $display("[TB] FAIL eqinv_mixed r%0d actual=%h round=%0d required=%h", k, out1, round1, ref_key(s, k, 1'b1));
            end
            if (k == 5) begin
                vectors++;
                if (out1 !== {4{32'hdb135345}}) begin
                    miscompares++;
                    $display("[TB] FAIL eqinv_vector actual=%h required=%h", out1, {4{32'hdb135345}});
                end
            end
            if (k == 10 || k == 0) begin
                vectors++;
                if (out1 !== s[1407-128*k -: 128]) begin
                    miscompares++;
                    $display("[TB] FAIL eqinv_edge_raw r%0d actual=%h required=%h", k, out1, s[1407-128*k -: 128]);
                end
            end
            tick();
        end
        vectors++;
        if ({done0, done1} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL eqinv_done actual=%b required=11", {done0, done1});
        end
        ready = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [1407:0] s;
        logic [265:0]  prev;
        logic [3:0]    pat;
        bit            stalled;
        bit            done_due;
        bit            finished;
        int            exp_k;
        int            delivered;
        s = rand_sched();
        pat = 4'b1001;
        sched = s; load = 1'b1; ready = 1'b0;
        tick();
        load = 1'b0;
        sched = rand_sched();
        exp_k = 10; delivered = 0;
        stalled = 1'b0; done_due = 1'b0; finished = 1'b0;
        prev = '0;
        for (int c = 0; c < 300 && !finished; c++) begin
            if (done_due) begin
                vectors++;
                if ({done0, done1, valid0, valid1} !== 4'b1100) begin
                    miscompares++;
                    $display("[TB] FAIL bp_done actual=%b required=1100", {done0, done1, valid0, valid1});
                end
                finished = 1'b1;
            end else begin
                if (stalled) begin
                    vectors++;
                    if ({out0, round0, last0, out1, round1, last1} !== prev) begin
                        miscompares++;
                        $display("[TB] FAIL bp_stall_hold cycle %0d actual=%h required=%h", c,
                                 {out0, round0, last0, out1, round1, last1}, prev);
                    end
                end
                ready = (c < 4) ? pat[c] : 1'($urandom_range(0, 1));
                if (ready) begin
                    vectors++;
                    if (valid0 !== 1'b1 || round0 !== 4'(exp_k) || last0 !== (exp_k == 0) ||
                        out0 !== ref_key(s, exp_k, 1'b0) || out1 !== ref_key(s, exp_k, 1'b1)) begin
                        miscompares++;
                        $display("[TB] FAIL bp_transfer actual=r%0d v%b %h required=r%0d %h",
                                 round0, valid0, out0, exp_k, ref_key(s, exp_k, 1'b0));
                    end
                    delivered++;
                    if (exp_k == 0) done_due = 1'b1;
                    else exp_k--;
                end
                stalled = !ready;
                prev = {out0, round0, last0, out1, round1, last1};
                tick();
            end
        end
        vectors++;
        if (!finished || delivered != 11) begin
            miscompares++;
            $display("[TB] FAIL bp_count actual=%0d finished=%b required=11", delivered, finished);
        end
        ready = 1'b0;
        tick();
    endtask

    task automatic test_load_ignored();
        logic [1407:0] sa;
        logic [1407:0] sb;
        sa = rand_sched();
        sb = rand_sched();
        sched = sa; load = 1'b1; ready = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 10; k >= 0; k--) begin
            if (k == 6) begin
                load = 1'b1;
                sched = sb;
            end else begin
                load = 1'b0;
            end
            vectors++;
            if (round0 !== 4'(k) || out0 !== ref_key(sa, k, 1'b0) || out1 !== ref_key(sa, k, 1'b1)) begin
                miscompares++;
                $display("[TB] FAIL load_ignored actual=r%0d %h required=r%0d %h", round0, out0, k, ref_key(sa, k, 1'b0));
            end
            tick();
        end
        load = 1'b0;
        vectors++;
        if ({done0, done1} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL load_ignored_done actual=%b required=11", {done0, done1});
        end
        ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [1407:0] s;
        s = rand_sched();
        sched = s; load = 1'b1; ready = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (round0 !== 4'd4) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_setup actual=%0d required=4", round0);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({busy0, valid0, last0, done0, busy1, valid1, last1, done1, round0, round1} !== 16'h0 ||
            {out0, out1} !== 256'h0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_outputs actual=%b %h required=0",
                     {busy0, valid0, last0, done0, busy1, valid1, last1, done1}, out0);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({done0, done1, valid0, valid1} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_no_done actual=%b required=0000", {done0, done1, valid0, valid1});
        end
        s = rand_sched();
        sched = s; load = 1'b1;
        tick();
        load = 1'b0;
        vectors++;
        if ({valid0, valid1} !== 2'b11 || round0 !== 4'd10 || out0 !== ref_key(s, 10, 1'b0) ||
            out1 !== ref_key(s, 10, 1'b1)) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_restart actual=v%b r%0d %h required=r10 %h",
                     valid0, round0, out0, ref_key(s, 10, 1'b0));
        end
        for (int i = 0; i < 11; i++) tick();
        vectors++;
        if ({done0, done1} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_done actual=%b required=11", {done0, done1});
        end
        ready = 1'b0;
        tick();
    endtask

    // With load held high, each stream is 11 key cycles plus one done cycle.
    task automatic test_back_to_back();
        logic [1407:0] s;
        logic [11:0]   expv;
        int            phase;
        int            rnd;
        s = rand_sched();
        sched = s; load = 1'b1; ready = 1'b1;
        tick();
        for (int c = 0; c < 36; c++) begin
            phase = c % 12;
            rnd = (phase == 11) ? 0 : 10 - phase;
            expv = {(phase != 11), (phase != 11), (phase == 11), (phase == 11), 4'(rnd), 4'(rnd)};
            vectors++;
            if ({valid0, valid1, done0, done1, round0, round1} !== expv) begin
                miscompares++;
                $display("[TB] FAIL b2b_ctl cycle %0d actual=%b required=%b", c,
                         {valid0, valid1, done0, done1, round0, round1}, expv);
            end
            if (phase != 11) begin
                vectors++;
                if (out0 !== ref_key(s, rnd, 1'b0) || out1 !== ref_key(s, rnd, 1'b1)) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_key cycle %0d actual=%h required=%h", c, out0, ref_key(s, rnd, 1'b0));
                end
            end
            tick();
        end
        load = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        vectors++;
        if ({done0, done1} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL b2b_final_done actual=%b required=11", {done0, done1});
        end
        ready = 1'b0;
        tick();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7367f6ac;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int k = 0; k <= 10; k++) fips_sched[1407-128*k -: 128] = fips_rk[k];

        test_reset();
        test_fips();
        test_eqinv();
        test_backpressure();
        test_load_ignored();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
